// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing HI/LO, with MTHI/MTLO support.
// One radix-2 shift-add or restoring-divide step per RUN cycle; sign fix-up applied on the last step.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] MtData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  // state  | meaning
  // S_IDLE | waiting for Start; Mt writes accepted
  // S_RUN  | one iteration per cycle, WIDTH cycles
  // S_FIN  | Done pulse, result in Hi/Lo; Start accepted back-to-back
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               op_signed, op_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next, prod_fin;
  logic [WIDTH-1:0]   quo_fin, rem_fin;

  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    op_signed = ~Op[0];
    op_div    = Op[1];
    a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
    b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, p_q[WIDTH-1:1]};

    // diff[WIDTH] set means the trial subtraction went negative: restore
    trial     = p_q[2*WIDTH-1:WIDTH-1];
    diff      = trial - {1'b0, m_q};
    div_next  = diff[WIDTH] ? {trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b1};
    step_next = is_div_q ? div_next : mul_next;

    prod_fin  = neg_q_q ? -step_next : step_next;
    quo_fin   = neg_q_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    rem_fin   = neg_r_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    m_d      = m_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (state_q != S_RUN) begin
      if (MtHi) hi_d = MtData;
      if (MtLo) lo_d = MtData;
    end

    case (state_q)
      S_RUN: begin
        p_d = step_next;
        if (cnt_q == '0) begin
          state_d = S_FIN;
          if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fin;
            lo_d = quo_fin;
          end else begin
            hi_d = prod_fin[2*WIDTH-1:WIDTH];
            lo_d = prod_fin[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (Start) begin
          state_d  = S_RUN;
          cnt_d    = CNT_LAST;
          is_div_d = op_div;
          a_raw_d  = A;
          neg_q_d  = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_r_d  = op_signed && A[WIDTH-1];
          dz_d     = op_div && (B == '0);
          m_d      = op_div ? b_mag : a_mag;
          p_d      = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
        end else if (state_q == S_FIN) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      m_q      <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      m_q      <= m_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign Busy      = (state_q == S_RUN);
  assign Done      = (state_q == S_FIN);
  assign DivByZero = (state_q == S_FIN) && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: expected results queued at Start from a 64-bit arithmetic model,
// compared by a monitor whenever Done is presented.
module tb_mult_div_unit;

  logic        Clk, Rst, Start, MtHi, MtLo;
  logic [1:0]  Op;
  logic [31:0] A, B, MtData, Hi, Lo;
  logic        Busy, Done, DivByZero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .MtHi(MtHi), .MtLo(MtLo), .MtData(MtData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic exp_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint sa, sbv, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    if (op[1] && b == 32'd0) begin
      e.dz = 1'b1;
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
    end else begin
      case (op)
        2'b00: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
        2'b01: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
        2'b10: begin q = sa / sbv; r = sa % sbv; e.hi = r[31:0]; e.lo = q[31:0]; end
        default: begin uq = ua / ub; ur = ua % ub; e.hi = ur[31:0]; e.lo = uq[31:0]; end
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst && Done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got Done=1 Hi=%h Lo=%h, expected no Done", Hi, Lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", Hi, e.hi);
        chk("result_lo", Lo, e.lo);
        chk("result_dz", {31'd0, DivByZero}, {31'd0, e.dz});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Start is held across exactly one edge; operands are then scrambled
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    sb.push_back(model(op, a, b));
    tick();
    Start = 1'b0;
    Op = 2'($urandom_range(0, 3));
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(input int exp_busy);
    int n;
    n = 0;
    chk("busy_on", {31'd0, Busy}, 32'd1);
    while (Busy && n < 40) begin
      n++;
      tick();
    end
    chk("busy_cycles", n, exp_busy);
    chk("done_pulse", {31'd0, Done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    Rst = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
    MtHi = 1'b0; MtLo = 1'b0; MtData = '0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_dz", {31'd0, DivByZero}, 32'd0);
    Rst = 1'b0;
    tick();

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(32);
    chk("multu_max_hi", Hi, 32'hFFFF_FFFE);
    tick();
    chk("fin_to_idle_done", {31'd0, Done}, 32'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5); wait_done(32);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(32);
    tick();

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2); wait_done(32); tick();
    run_op(2'b11, 32'd100, 32'd7); wait_done(32); tick();
    run_op(2'b11, 32'd7, 32'd0); wait_done(32);
    chk("dz_in_done", {31'd0, DivByZero}, 32'd1);
    tick();
    chk("dz_cleared", {31'd0, DivByZero}, 32'd0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(32); tick();

    // Start and MtHi during RUN must be ignored
    run_op(2'b01, 32'd3, 32'd4);
    repeat (4) tick();
    Start = 1'b1; Op = 2'b11; A = 32'd99; B = 32'd5; MtHi = 1'b1; MtData = 32'h0000_DEAD;
    tick();
    Start = 1'b0; MtHi = 1'b0;
    chk("mthi_ignored_busy", Hi, 32'd0);
    wait_done(27);
    tick();

    MtLo = 1'b1; MtData = 32'h0000_1234;
    tick();
    MtLo = 1'b0;
    chk("mtlo_idle_lo", Lo, 32'h0000_1234);
    chk("mtlo_idle_hi", Hi, 32'd0);
    MtHi = 1'b1; MtLo = 1'b1; MtData = 32'hA5A5_5A5A;
    tick();
    MtHi = 1'b0; MtLo = 1'b0;
    chk("mtboth_hi", Hi, 32'hA5A5_5A5A);
    chk("mtboth_lo", Lo, 32'hA5A5_5A5A);
    repeat (2) tick();
    chk("hi_retained", Hi, 32'hA5A5_5A5A);

    // Mt write coincident with Start lands first, result overwrites later
    MtHi = 1'b1; MtData = 32'hCAFE_0000;
    run_op(2'b01, 32'd6, 32'd7);
    MtHi = 1'b0;
    chk("mt_with_start_hi", Hi, 32'hCAFE_0000);
    wait_done(32);
    tick();

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb);
      wait_done(32);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // Mid-operation reset aborts without a Done
    run_op(2'b01, $urandom, $urandom);
    repeat (9) tick();
    Rst = 1'b1;
    void'(sb.pop_back());
    tick();
    Rst = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", Hi, 32'd0);
    chk("abort_lo", Lo, 32'd0);
    done_cnt = 0;
    repeat (40) begin
      tick();
      if (Done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two register-read operands (BusA/BusB values) and produces the HI/LO architectural registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles with a Busy/Done handshake, so the pipeline controller can stall MFHI/MFLO.
- Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  reset; synchronous, active-high.
- Start  input  1  request a new operation; honoured only when Busy=0.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- A  input  WIDTH  operand rs (multiplicand/dividend); sampled with Start.
- B  input  WIDTH  operand rt (multiplier/divisor); sampled with Start.
- MtHi  input  1  write MtData into Hi; honoured only when Busy=0.
- MtLo  input  1  write MtData into Lo; honoured only when Busy=0.
- MtData  input  WIDTH  data for MTHI/MTLO.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result this cycle.
- DivByZero  output  1  valid with Done; 1 if a DIV/DIVU had B=0.

Behaviour:
- Reset: at any posedge with Rst=1, state→IDLE, Hi=Lo=0, Busy=0, Done=0, DivByZero=0, and internal accumulators/counter cleared. Rst overrides Start, MtHi and MtLo. Mid-operation reset aborts the operation; no Done is issued.
- States:
  - IDLE: Busy=0, Done=0.
  - RUN: Busy=1, WIDTH cycles.
  - FIN: Busy=0, Done=1, one cycle.
- Transitions:
  - IDLE → RUN on Start.
  - RUN → FIN when the counter expires after WIDTH iterations.
  - FIN → RUN on Start; FIN → IDLE otherwise.
- Timing: Start sampled at edge E0. Busy is high for exactly WIDTH cycles after E0. Done, with new Hi/Lo and DivByZero, is visible in cycle WIDTH+1 after E0 (33 for WIDTH=32). Back-to-back Start in the FIN cycle is accepted with no idle cycle.
- Start while Busy=1: ignored; A, B and Op changes during RUN have no effect.
- MtHi/MtLo while Busy=1: ignored.
- MtHi/MtLo while Busy=0: written at that edge. Both may assert together, writing both registers.
- MtHi/MtLo with Start on the same edge: the Mt write happens; the result later overwrites Hi/Lo.
- Multiply: radix-2 shift-add on magnitudes, one bit per cycle. Result is a 2*WIDTH product; Hi = upper half, Lo = lower half.
  - MULTU: operands unsigned.
  - MULT: two's complement. Magnitudes are taken at Start; the product is negated in the final step if the operand signs differ.
- Divide: restoring division on magnitudes, one quotient bit per cycle. Lo = quotient, Hi = remainder.
  - DIVU: unsigned.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0; no trap.
- Divide by zero: still takes the full WIDTH cycles. Result is Hi=A (raw as sampled), Lo=all ones, DivByZero=1 during the Done cycle, for both DIV and DIVU.
- DivByZero is 0 for multiplies and for nonzero divisors. It is cleared to 0 outside the Done cycle.
- Hi/Lo retain their values in all cycles except reset, an accepted Mt write, or result load.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → Busy high for 32 cycles; in cycle 33 Done=1, Hi=0xFFFFFFFE, Lo=0x00000001, DivByZero=0.
- MULT A=0xFFFFFFFD (−3) B=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Then Start in the FIN cycle with MULT A=0xFFFFFFFF B=0xFFFFFFFF → Busy reasserts next cycle; result Hi=0, Lo=1.
- DIV A=0xFFFFFFF9 (−7) B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=100 B=7 → Lo=14, Hi=2.
- DIVU A=7 B=0 → Done after 33 cycles with Hi=7, Lo=0xFFFFFFFF, DivByZero=1. DIV A=0x80000000 B=0xFFFFFFFF → Lo=0x80000000, Hi=0, DivByZero=0.
- Start MULTU 3*4, then Start DIVU and MtHi=0xDEAD at cycle 5 → both ignored; result Hi=0, Lo=12. MtLo=0x1234 while idle → Lo=0x1234 the next cycle.
- Start MULTU, assert Rst at cycle 10 → next cycle Busy=0, Hi=Lo=0, and no Done pulse in the following 40 cycles.
